// File: rtl/insight_dcache_resp_tracer.sv
// DCache response tracer: filters response events, timestamps them and queues
// them in a small FIFO. Drops are counted, and the next queued record carries a lost flag.
module insight_dcache_resp_tracer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6,
  parameter int SIZE_W = 2,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_enable,
  input  logic [31:0]                cfg_cmd_mask,
  input  logic                       cfg_miss_only,
  input  logic                       resp_valid,
  input  logic                       resp_miss,
  input  logic [ADDR_W-1:0]          resp_addr,
  input  logic [DATA_W-1:0]          resp_rdata,
  input  logic [ID_W-1:0]            resp_id,
  input  logic [4:0]                 resp_cmd,
  input  logic                       resp_signed,
  input  logic [SIZE_W-1:0]          resp_size,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [TS_W-1:0]            trace_ts,
  output logic                       trace_miss,
  output logic [ADDR_W-1:0]          trace_addr,
  output logic [DATA_W-1:0]          trace_rdata,
  output logic [ID_W-1:0]            trace_id,
  output logic [4:0]                 trace_cmd,
  output logic                       trace_signed,
  output logic [SIZE_W-1:0]          trace_size,
  output logic                       trace_lost,
  output logic [15:0]                drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = TS_W + 1 + ADDR_W + DATA_W + ID_W + 5 + 1 + SIZE_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  // Handshake: a record moves out on any cycle where trace_valid && trace_ready;
  // trace_valid never depends on trace_ready. The response side has no backpressure.
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0]  ts;
  logic             lost_pending;
  logic             qual, pop, push, drop;
  logic [REC_W-1:0] wr_rec, head;
  logic             head_miss, head_lost;

  assign qual = resp_valid & cfg_enable & cfg_cmd_mask[resp_cmd] & (~cfg_miss_only | resp_miss);
  assign trace_valid = (fifo_level != '0);
  assign pop  = trace_valid & trace_ready & ~reset;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push = qual & ~reset & ((fifo_level != FULL_LEVEL) | pop);
  assign drop = qual & ~reset & ~push;

  assign wr_rec = {ts, resp_miss, resp_addr, resp_rdata, resp_id, resp_cmd,
                   resp_signed, resp_size, lost_pending};
  assign head = mem[rd_ptr];
  assign {trace_ts, head_miss, trace_addr, trace_rdata, trace_id, trace_cmd,
          trace_signed, trace_size, head_lost} = head;
  // Storage is not reset, so flag bits are masked to stay clean while empty.
  assign trace_miss = trace_valid & head_miss;
  assign trace_lost = trace_valid & head_lost;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      drop_count   <= '0;
      lost_pending <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (push)      lost_pending <= 1'b0;
      else if (drop) lost_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_insight_dcache_resp_tracer.sv
// Directed bench for insight_dcache_resp_tracer: filtering, overflow and lost flag,
// full push/pop, counter wrap/saturation and mid-stream reset.
module tb_insight_dcache_resp_tracer;

  logic        clock, reset;
  logic        cfg_enable, cfg_miss_only;
  logic [31:0] cfg_cmd_mask;
  logic        resp_valid, resp_miss, resp_signed;
  logic [31:0] resp_addr, resp_rdata;
  logic [5:0]  resp_id;
  logic [4:0]  resp_cmd;
  logic [1:0]  resp_size;
  logic        trace_valid, trace_ready, trace_miss, trace_signed, trace_lost;
  logic [15:0] trace_ts, drop_count;
  logic [31:0] trace_addr, trace_rdata;
  logic [5:0]  trace_id;
  logic [4:0]  trace_cmd;
  logic [1:0]  trace_size;
  logic [3:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  insight_dcache_resp_tracer dut (
    .clock(clock), .reset(reset),
    .cfg_enable(cfg_enable), .cfg_cmd_mask(cfg_cmd_mask), .cfg_miss_only(cfg_miss_only),
    .resp_valid(resp_valid), .resp_miss(resp_miss), .resp_addr(resp_addr),
    .resp_rdata(resp_rdata), .resp_id(resp_id), .resp_cmd(resp_cmd),
    .resp_signed(resp_signed), .resp_size(resp_size),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_ts(trace_ts),
    .trace_miss(trace_miss), .trace_addr(trace_addr), .trace_rdata(trace_rdata),
    .trace_id(trace_id), .trace_cmd(trace_cmd), .trace_signed(trace_signed),
    .trace_size(trace_size), .trace_lost(trace_lost),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // driver tasks
  task automatic send_event(input logic [4:0] cmd, input logic miss, input logic [31:0] addr);
    resp_valid = 1'b1; resp_cmd = cmd; resp_miss = miss; resp_addr = addr;
    resp_rdata = ~addr; resp_id = addr[5:0]; resp_signed = addr[0]; resp_size = addr[2:1];
    @(posedge clock); #1;
    resp_valid = 1'b0;
  endtask

  task automatic pop_one();
    trace_ready = 1'b1;
    @(posedge clock); #1;
    trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (trace_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", trace_valid); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (trace_lost !== 1'b0 || trace_miss !== 1'b0)
      $display("FAIL reset_flags: got lost=%b miss=%b want 0 0", trace_lost, trace_miss); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    cfg_enable = 1'b1; cfg_cmd_mask = 32'hFFFF_FFFF; cfg_miss_only = 1'b0;
    idle(5);
    send_event(5'd0, 1'b0, 32'h8000_1000);
    n_checks++; if (trace_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", trace_valid); else n_pass++;
    n_checks++; if (trace_ts !== 16'd5) $display("FAIL single_ts: got %0d want 5", trace_ts); else n_pass++;
    n_checks++; if (trace_addr !== 32'h8000_1000) $display("FAIL single_addr: got %h want 80001000", trace_addr); else n_pass++;
    n_checks++; if (trace_rdata !== 32'h7FFF_EFFF || trace_id !== 6'd0 || trace_cmd !== 5'd0)
      $display("FAIL single_fields: got rdata=%h id=%0d cmd=%0d want 7fffefff 0 0", trace_rdata, trace_id, trace_cmd); else n_pass++;
    n_checks++; if (trace_lost !== 1'b0) $display("FAIL single_lost: got %b want 0", trace_lost); else n_pass++;
    pop_one();
    n_checks++; if (trace_valid !== 1'b0 || fifo_level !== 4'd0)
      $display("FAIL single_drain: got valid=%b level=%0d want 0 0", trace_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_filter();
    do_reset();
    cfg_enable = 1'b1; cfg_cmd_mask = 32'h0000_0001; cfg_miss_only = 1'b0;
    send_event(5'd1, 1'b0, 32'h0000_2000);
    send_event(5'd0, 1'b0, 32'h0000_3000);
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL filter_mask_level: got %0d want 1", fifo_level); else n_pass++;
    n_checks++; if (trace_addr !== 32'h0000_3000) $display("FAIL filter_mask_addr: got %h want 00003000", trace_addr); else n_pass++;
    pop_one();
    cfg_miss_only = 1'b1;
    send_event(5'd0, 1'b0, 32'h0000_4000);
    n_checks++; if (fifo_level !== 4'd0 || drop_count !== 16'd0)
      $display("FAIL filter_miss_only: got level=%0d drop=%0d want 0 0", fifo_level, drop_count); else n_pass++;
    send_event(5'd0, 1'b1, 32'h0000_5000);
    n_checks++; if (trace_valid !== 1'b1 || trace_miss !== 1'b1 || trace_addr !== 32'h0000_5000)
      $display("FAIL filter_miss_pass: got valid=%b miss=%b addr=%h want 1 1 00005000", trace_valid, trace_miss, trace_addr); else n_pass++;
    pop_one();
    cfg_miss_only = 1'b0; cfg_enable = 1'b0;
    send_event(5'd0, 1'b1, 32'h0000_6000);
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL filter_disable: got %0d want 0", fifo_level); else n_pass++;
    cfg_enable = 1'b1; cfg_cmd_mask = 32'hFFFF_FFFF;
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_event(5'(i), 1'b0, 32'h100 + 32'(i));
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", fifo_level); else n_pass++;
    n_checks++; if (drop_count !== 16'd2) $display("FAIL ovf_drop: got %0d want 2", drop_count); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (trace_addr !== 32'h100 + 32'(i) || trace_lost !== 1'b0)
        $display("FAIL ovf_order%0d: got addr=%h lost=%b want %h 0", i, trace_addr, trace_lost, 32'h100 + 32'(i)); else n_pass++;
      pop_one();
    end
    send_event(5'd3, 1'b0, 32'h0000_0A00);
    n_checks++; if (trace_lost !== 1'b1 || trace_addr !== 32'h0000_0A00)
      $display("FAIL ovf_lost_set: got lost=%b addr=%h want 1 00000a00", trace_lost, trace_addr); else n_pass++;
    send_event(5'd4, 1'b0, 32'h0000_0B00);
    pop_one();
    n_checks++; if (trace_lost !== 1'b0 || trace_addr !== 32'h0000_0B00)
      $display("FAIL ovf_lost_clr: got lost=%b addr=%h want 0 00000b00", trace_lost, trace_addr); else n_pass++;
    pop_one();
  endtask

  task automatic test_back_to_back();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_event(5'd2, 1'b0, 32'h200 + 32'(i));
    trace_ready = 1'b1;
    send_event(5'd2, 1'b0, 32'h0000_02FF);
    trace_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd8 || drop_count !== 16'd0)
      $display("FAIL full_pushpop: got level=%0d drop=%0d want 8 0", fifo_level, drop_count); else n_pass++;
    n_checks++; if (trace_addr !== 32'h0000_0201) $display("FAIL full_head: got %h want 00000201", trace_addr); else n_pass++;
    repeat (7) pop_one();
    n_checks++; if (trace_addr !== 32'h0000_02FF || fifo_level !== 4'd1)
      $display("FAIL full_tail: got addr=%h level=%0d want 000002ff 1", trace_addr, fifo_level); else n_pass++;
    pop_one();
    n_checks++; if (trace_valid !== 1'b0) $display("FAIL full_empty: got %b want 0", trace_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_event(5'd0, 1'b1, 32'h300 + 32'(i));
    n_checks++; if (fifo_level !== 4'd5) $display("FAIL mid_level_pre: got %0d want 5", fifo_level); else n_pass++;
    do_reset();
    n_checks++; if (trace_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0)
      $display("FAIL mid_reset: got valid=%b level=%0d drop=%0d want 0 0 0", trace_valid, fifo_level, drop_count); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    trace_ready = 1'b0;
    resp_valid = 1'b1; resp_cmd = 5'd0; resp_miss = 1'b0; resp_addr = 32'h0000_0400;
    repeat (32'h1000C) @(posedge clock);
    #1;
    resp_valid = 1'b0;
    n_checks++; if (drop_count !== 16'hFFFF) $display("FAIL wrap_drop_sat: got %h want ffff", drop_count); else n_pass++;
    n_checks++; if (fifo_level !== 4'd8 || trace_ts !== 16'd0)
      $display("FAIL wrap_full: got level=%0d ts=%0d want 8 0", fifo_level, trace_ts); else n_pass++;
    trace_ready = 1'b1;
    idle(8);
    trace_ready = 1'b0;
    send_event(5'd0, 1'b0, 32'h0000_0500);
    n_checks++; if (trace_ts !== 16'd20 || trace_lost !== 1'b1)
      $display("FAIL wrap_ts: got ts=%0d lost=%b want 20 1", trace_ts, trace_lost); else n_pass++;
    n_checks++; if (drop_count !== 16'hFFFF) $display("FAIL wrap_drop_hold: got %h want ffff", drop_count); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; cfg_enable = 1'b0; cfg_cmd_mask = '0; cfg_miss_only = 1'b0;
    resp_valid = 1'b0; resp_miss = 1'b0; resp_addr = '0; resp_rdata = '0;
    resp_id = '0; resp_cmd = '0; resp_signed = 1'b0; resp_size = '0; trace_ready = 1'b0;
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/insight_dcache_resp_tracer.md
INSIGHT_DCACHE_RESP_TRACER -- requirements
Module: insight_dcache_resp_tracer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width (virtual or physical).
REQ-002 SHALL have parameter DATA_W, default 32, response data width.
REQ-003 SHALL have parameter ID_W, default 6, cache transaction id width.
REQ-004 SHALL have parameter SIZE_W, default 2, width of log2-bytes size field.
REQ-005 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, >=2.
REQ-006 SHALL have parameter TS_W, default 16, timestamp width.
REQ-007 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-008 SHALL have ports: cfg_enable in 1 capture enable; cfg_cmd_mask in 32 per-cmd capture enable, bit k = cmd k; cfg_miss_only in 1 capture only misses.
REQ-009 SHALL have ports: resp_valid in 1; resp_miss in 1; resp_addr in ADDR_W; resp_rdata in DATA_W; resp_id in ID_W; resp_cmd in 5; resp_signed in 1; resp_size in SIZE_W -- one DCache response event per valid cycle, no backpressure.
REQ-010 SHALL have ports: trace_valid out 1; trace_ready in 1; trace_ts out TS_W; trace_miss, trace_addr, trace_rdata, trace_id, trace_cmd, trace_signed, trace_size out (widths as resp_*); trace_lost out 1 (events dropped before this record).
REQ-011 SHALL have ports: drop_count out 16 saturating dropped-event count; fifo_level out clog2(DEPTH)+1 occupancy.

Function
REQ-012 SHALL run a free-running TS_W timestamp counter, +1 every cycle, wrapping to 0 after all-ones.
REQ-013 SHALL qualify an event as: resp_valid & cfg_enable & cfg_cmd_mask[resp_cmd] & (!cfg_miss_only | resp_miss).
REQ-014 SHALL capture a qualified event as a record {ts = counter value that cycle, all resp_* fields, lost flag}.
REQ-015 SHALL push a qualified event when fifo_level < DEPTH, or when fifo_level == DEPTH and a pop occurs the same cycle.
REQ-016 SHALL otherwise drop the event: drop_count += 1 saturating at 0xFFFF; internal lost_pending set.
REQ-017 SHALL set lost flag of the next pushed record to lost_pending, then clear lost_pending on that push; a drop and push cannot coincide.
REQ-018 SHALL pop when trace_valid & trace_ready; trace_valid = (fifo_level != 0).
REQ-019 SHALL present head record on trace_* combinationally from storage; fields stable while trace_valid & !trace_ready.
REQ-020 SHALL have latency 1: record qualified in cycle N visible with trace_valid in cycle N+1 if FIFO empty at N.
REQ-021 SHALL update fifo_level: +1 push only, -1 pop only, unchanged both or neither.
REQ-022 SHALL use wrap-around read/write pointers of clog2(DEPTH) bits.
REQ-023 SHALL not pop on empty; trace_ready with trace_valid=0 has no effect.
REQ-024 SHALL apply cfg_* changes to events in the same cycle; records already queued unaffected.
REQ-025 SHALL deassert cfg_enable without flushing; queued records still drain.
REQ-026 SHALL treat trace_* fields as don't-care while trace_valid=0.

Reset
REQ-027 SHALL on reset: fifo_level=0, trace_valid=0, pointers=0, timestamp=0, drop_count=0, lost_pending=0.
REQ-028 SHALL ignore resp_valid and trace_ready in the reset cycle; mid-operation reset discards all queued records and the pending lost flag.
REQ-029 SHALL drive trace_lost=0, trace_miss=0 while empty after reset.

Verification
REQ-030 Single event: reset, cfg_enable=1, mask=all-ones, load cmd=0 addr=0x80001000 at ts=5 -> cycle+1 trace_valid=1, trace_ts=5, trace_addr=0x80001000, trace_lost=0.
REQ-031 Filter: mask=0x00000001, cmd=1 store then cmd=0 load -> only load queued; cfg_miss_only=1 with resp_miss=0 -> nothing queued, drop_count=0.
REQ-032 Overflow: DEPTH=8, trace_ready=0, 10 qualified events -> fifo_level=8, drop_count=2; drain 8; next event record trace_lost=1, following trace_lost=0.
REQ-033 Full + simultaneous pop and push: fifo_level=8, trace_ready=1, qualified event -> pushed, fifo_level stays 8, drop_count unchanged.
REQ-034 Wrap: run 0x10000 cycles -> timestamp returns to 0; 0xFFFF+5 drops -> drop_count=0xFFFF.
REQ-035 Reset mid-stream: 5 queued, assert reset one cycle -> next cycle trace_valid=0, fifo_level=0, drop_count=0.
